// File: rtl/joy_serial_rx.sv
// Serial joystick receiver: drives LOAD/CLK to a PISO shift-register chain and publishes PLAYERS*BITS buttons once per frame.
// Optional macro JOY_SERIAL_RX_DEBOUNCE_EN: joystick only updates after two consecutive identical frames.
module joy_serial_rx #(
  parameter int unsigned PLAYERS    = 2,
  parameter int unsigned BITS       = 12,
  parameter int unsigned CLK_DIV    = 24,
  parameter int unsigned GAP_CYCLES = 1024
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    joy_data,
  output logic                    joy_clk,
  output logic                    joy_load,
  output logic [PLAYERS*BITS-1:0] joystick,
  output logic                    present,
  output logic                    frame_done
);

  localparam int unsigned N     = PLAYERS * BITS;
  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BIT_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_SAMPLE,
    S_SHIFT,
    S_LATCH,
    S_GAP
  } state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [N-1:0]     shift_q, shift_d;
  logic [N-1:0]     joystick_q, joystick_d;
  logic             present_q, present_d;
  logic             frame_done_q, frame_done_d;
  logic             joy_clk_q, joy_clk_d;
  logic             joy_load_q, joy_load_d;
`ifdef JOY_SERIAL_RX_DEBOUNCE_EN
  logic [N-1:0]     prev_q, prev_d;
`endif

  logic tick;
  logic last_bit;
  logic gap_end;
  logic disconnected;

  assign tick     = (div_q == DIV_W'(CLK_DIV - 1));
  assign last_bit = (bit_q == BIT_W'(N - 1));
  assign gap_end  = (gap_q == GAP_W'(GAP_CYCLES - 1));
  // Every raw bit sampled low means every inverted bit is high: the line is stuck low.
  assign disconnected = &shift_q;

  // State register
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; dropping enable aborts only at a half-period boundary
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (enable) state_d = S_LOAD;
      S_LOAD:   if (tick) state_d = enable ? S_SETTLE : S_IDLE;
      S_SETTLE: if (tick) state_d = enable ? S_SAMPLE : S_IDLE;
      S_SAMPLE: if (tick) state_d = enable ? S_SHIFT : S_IDLE;
      S_SHIFT: begin
        if (tick) begin
          if (!enable)      state_d = S_IDLE;
          else if (last_bit) state_d = S_LATCH;
          else               state_d = S_SAMPLE;
        end
      end
      S_LATCH:  state_d = S_GAP;
      S_GAP:    if (gap_end) state_d = enable ? S_LOAD : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Counters and shift register
  always_comb begin
    div_d   = '0;
    bit_d   = bit_q;
    gap_d   = '0;
    shift_d = shift_q;
    unique case (state_q)
      S_LOAD, S_SETTLE, S_SAMPLE, S_SHIFT: div_d = tick ? '0 : div_q + DIV_W'(1);
      default: div_d = '0;
    endcase
    if (state_q == S_SETTLE && tick) begin
      bit_d = '0;
    end
    if (state_q == S_SHIFT && tick && !last_bit) begin
      bit_d = bit_q + BIT_W'(1);
    end
    if (state_q == S_SAMPLE && tick) begin
      shift_d[bit_q] = ~joy_data;
    end
    if (state_q == S_GAP) begin
      gap_d = gap_end ? '0 : gap_q + GAP_W'(1);
    end
  end

  // Output logic; pin outputs are registered from the next state so they line up with state_q
  always_comb begin
    joystick_d   = joystick_q;
    present_d    = present_q;
    frame_done_d = (state_q == S_LATCH);
    joy_clk_d    = (state_d == S_SHIFT);
    joy_load_d   = (state_d != S_LOAD);
`ifdef JOY_SERIAL_RX_DEBOUNCE_EN
    prev_d       = prev_q;
`endif
    if (state_q == S_LATCH) begin
      if (disconnected) begin
        joystick_d = '0;
        present_d  = 1'b0;
`ifdef JOY_SERIAL_RX_DEBOUNCE_EN
        prev_d     = '0;
`endif
      end else begin
        present_d  = 1'b1;
`ifdef JOY_SERIAL_RX_DEBOUNCE_EN
        if (shift_q == prev_q) begin
          joystick_d = shift_q;
        end
        prev_d = shift_q;
`else
        joystick_d = shift_q;
`endif
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      div_q        <= '0;
      bit_q        <= '0;
      gap_q        <= '0;
      shift_q      <= '0;
      joystick_q   <= '0;
      present_q    <= 1'b0;
      frame_done_q <= 1'b0;
      joy_clk_q    <= 1'b0;
      joy_load_q   <= 1'b1;
`ifdef JOY_SERIAL_RX_DEBOUNCE_EN
      prev_q       <= '0;
`endif
    end else begin
      div_q        <= div_d;
      bit_q        <= bit_d;
      gap_q        <= gap_d;
      shift_q      <= shift_d;
      joystick_q   <= joystick_d;
      present_q    <= present_d;
      frame_done_q <= frame_done_d;
      joy_clk_q    <= joy_clk_d;
      joy_load_q   <= joy_load_d;
`ifdef JOY_SERIAL_RX_DEBOUNCE_EN
      prev_q       <= prev_d;
`endif
    end
  end

  assign joy_clk    = joy_clk_q;
  assign joy_load   = joy_load_q;
  assign joystick   = joystick_q;
  assign present    = present_q;
  assign frame_done = frame_done_q;

endmodule
